// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer and the downstream load extractor.
// Size encodings here must stay in sync with the extractor's decode.
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_BU = 3'b001;
    localparam logic [2:0] SZ_H  = 3'b010;
    localparam logic [2:0] SZ_HU = 3'b011;
    localparam logic [2:0] SZ_W  = 3'b100;

    localparam int unsigned TimerW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

endpackage

// File: rtl/lsu_store_align.sv
// Combinational store lane steering: byte enables, replicated write data and
// misalignment / illegal-size detection for one request.
module lsu_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic        illegal_o
);

    always_comb begin
        be_o        = 4'b0000;
        wdata_rep_o = wdata_i;
        illegal_o   = 1'b0;
        case (size_i)
            SZ_B, SZ_BU: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o = {2{wdata_i[15:0]}};
                illegal_o   = addr_lo_i[0];
            end
            SZ_W: begin
                be_o      = 4'b1111;
                illegal_o = (addr_lo_i != 2'b00);
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store bus sequencer: accepts one request, drives a word-aligned bus access
// with ack timeout, and captures load data into the memory buffer register.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mbr,
    output logic [31:0] delayed_addr,
    output logic [2:0]  size_q,
    output logic        done,
    output logic        err_align,
    output logic        err_bus
);

    localparam logic [TimerW-1:0] TimeoutCnt = TimerW'(TIMEOUT);

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [31:0]       mbr_q, mbr_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        size_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_align_q, err_align_d;
    logic              err_bus_q, err_bus_d;

    logic [3:0]        align_be;
    logic [31:0]       align_wdata;
    logic              align_illegal;

    lsu_store_align u_store_align (
        .size_i      (req_size),
        .addr_lo_i   (req_addr[1:0]),
        .wdata_i     (req_wdata),
        .be_o        (align_be),
        .wdata_rep_o (align_wdata),
        .illegal_o   (align_illegal)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        mbr_d       = mbr_q;
        addr_d      = addr_q;
        size_d      = size_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        err_align_d = err_align_q;
        err_bus_d   = err_bus_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    size_d      = req_size;
                    we_d        = req_we;
                    be_d        = align_be;
                    wdata_d     = align_wdata;
                    timer_d     = '0;
                    err_align_d = align_illegal;
                    err_bus_d   = 1'b0;
                    state_d     = align_illegal ? StResp : StBusy;
                end
            end
            StBusy: begin
                // Ack has priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    if (!we_q) begin
                        mbr_d = mem_rdata;
                    end
                    state_d = StResp;
                end else if (timer_q == TimeoutCnt) begin
                    err_bus_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StResp: begin
                err_align_d = 1'b0;
                err_bus_d   = 1'b0;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            mbr_q       <= '0;
            addr_q      <= '0;
            size_q      <= 3'b000;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            err_align_q <= 1'b0;
            err_bus_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mbr_q       <= mbr_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            err_align_q <= err_align_d;
            err_bus_q   <= err_bus_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign mem_req      = (state_q == StBusy);
    assign mem_we       = mem_req & we_q;
    assign mem_be       = mem_req ? be_q : 4'b0000;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_wdata    = wdata_q;
    assign mbr          = mbr_q;
    assign delayed_addr = addr_q;
    assign done         = (state_q == StResp);
    assign err_align    = done & err_align_q;
    assign err_bus      = done & err_bus_q;

endmodule
